// File: rtl/fft_frame_arbiter.sv
// Round-robin frame arbiter that shares one FFT core between NCH sample streams
// and steers the core's output frames back to their owners through a tag FIFO.
module fft_frame_arbiter #(
  parameter int NCH       = 2,
  parameter int FRAME     = 64,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH-1:0]    req_inv,
  input  logic [16*NCH-1:0] req_re,
  input  logic [16*NCH-1:0] req_im,
  output logic              core_valid_in,
  output logic              core_sop_in,
  output logic              core_inv,
  output logic [15:0]       core_x_re,
  output logic [15:0]       core_x_im,
  input  logic              core_valid_out,
  input  logic              core_sop_out,
  input  logic [15:0]       core_y_re,
  input  logic [15:0]       core_y_im,
  output logic [NCH-1:0]    out_valid,
  output logic [NCH-1:0]    out_sop,
  output logic [15:0]       out_re,
  output logic [15:0]       out_im,
  output logic              busy,
  output logic              err
);
  localparam int GW = (NCH > 2) ? 2 : 1;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t          state;
  logic [GW-1:0]   gnt;
  logic [GW-1:0]   rr_ptr;
  logic [5:0]      cnt;
  logic [GW-1:0]   tag_mem [TAG_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [GW-1:0]   cur_tag;
  logic            tag_ok;

  logic            found;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  logic            full;
  logic            beat;
  logic            last;
  logic            pop;
  logic [GW-1:0]   next_tag;
  logic            next_ok;
  logic [NCH-1:0]  valid_n;
  logic [NCH-1:0]  sop_n;

  // Scan channels cyclically starting just after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    cand  = rr_ptr;
    for (int i = 0; i < NCH; i++) begin
      cand = (cand == GW'(NCH - 1)) ? '0 : cand + 1'b1;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign full = (count == CW'(TAG_DEPTH));
  assign beat = (state == STREAM) && req_valid[gnt];
  assign last = beat && (cnt == 6'(FRAME - 1));
  assign pop  = core_sop_out && (count != '0);
  assign busy = (state == STREAM) || (count != '0);

  always_comb begin
    req_ready = '0;
    if (state == STREAM) begin
      req_ready[gnt] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Grant FSM and the registered input-side mux into the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gnt           <= '0;
      rr_ptr        <= GW'(NCH - 1);
      cnt           <= 6'd0;
      core_valid_in <= 1'b0;
      core_sop_in   <= 1'b0;
      core_inv      <= 1'b0;
      core_x_re     <= 16'd0;
      core_x_im     <= 16'd0;
    end else begin
      core_valid_in <= beat;
      core_sop_in   <= beat && (cnt == 6'd0);
      if (beat) begin
        core_x_re <= req_re[16*gnt +: 16];
        core_x_im <= req_im[16*gnt +: 16];
        cnt       <= cnt + 6'd1;
        if (cnt == 6'd0) begin
          core_inv <= req_inv[gnt];
        end
      end
      case (state)
        IDLE: begin
          if (found && !full) begin
            gnt    <= pick;
            rr_ptr <= pick;
            cnt    <= 6'd0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          if (last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag FIFO: a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (last) begin
        tag_mem[wr_ptr] <= gnt;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(last) - CW'(pop);
    end
  end

  // A frame start selects its owner; an untagged frame stays silent throughout.
  assign next_tag = pop ? tag_mem[rd_ptr] : cur_tag;
  assign next_ok  = core_sop_out ? pop : tag_ok;

  always_comb begin
    valid_n = '0;
    sop_n   = '0;
    for (int c = 0; c < NCH; c++) begin
      valid_n[c] = next_ok && (next_tag == GW'(c)) && core_valid_out;
      sop_n[c]   = next_ok && (next_tag == GW'(c)) && core_sop_out;
    end
  end

  // Registered output steering and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_tag   <= '0;
      tag_ok    <= 1'b0;
      out_valid <= '0;
      out_sop   <= '0;
      out_re    <= 16'd0;
      out_im    <= 16'd0;
      err       <= 1'b0;
    end else begin
      cur_tag   <= next_tag;
      tag_ok    <= next_ok;
      out_valid <= valid_n;
      out_sop   <= sop_n;
      out_re    <= core_y_re;
      out_im    <= core_y_im;
      if (core_sop_out && !pop) begin
        err <= 1'b1;
      end
    end
  end
endmodule
